// File: rtl/mark_counter_body.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mark_counter_body: body mark of the Golomb ruler search chain; finds    |
// | the next position whose distances to all upstream marks are new.       |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module mark_counter_body #(
   parameter int POS_W    = 8,
   parameter int NUM_PREV = 2,
   parameter int MAX_LEN  = 25
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load,
   input  logic                      advance,
   input  logic [POS_W-1:0]          start_value,
   input  logic [NUM_PREV*POS_W-1:0] prev_marks,
   input  logic [MAX_LEN-1:0]        used_in,
   output logic [POS_W-1:0]          val,
   output logic [POS_W-1:0]          nextStartValue,
   output logic [MAX_LEN-1:0]        used_out,
   output logic                      ready,
   output logic                      exhausted
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_FOUND = 2'd2,
      S_EXH   = 2'd3
   } state_t;

   localparam int               IDX_W      = (NUM_PREV > 1) ? $clog2(NUM_PREV) : 1;
   localparam logic [POS_W:0]   C_MAX_LEN  = (POS_W+1)'(MAX_LEN);
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_PREV-1);
   localparam logic [MAX_LEN-1:0] C_ONE    = MAX_LEN'(1);

   state_t                    state_q, state_d;
   logic [POS_W:0]            cand_q, cand_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [MAX_LEN-1:0]        loc_q, loc_d;
   logic [NUM_PREV*POS_W-1:0] prev_q, prev_d;
   logic [MAX_LEN-1:0]        used_q, used_d;
   logic [POS_W-1:0]          val_q, val_d;
   logic [POS_W-1:0]          nsv_q, nsv_d;
   logic [MAX_LEN-1:0]        uo_q, uo_d;
   logic                      ready_q, ready_d;
   logic                      exh_q, exh_d;

   logic [POS_W-1:0]          w_mark;
   logic [POS_W-1:0]          w_cand_lo;
   logic [POS_W-1:0]          w_diff;
   logic [MAX_LEN-1:0]        w_dbit;
   logic                      w_fail;

   always_comb begin
      w_mark = '0;
      for (int k = 0; k < NUM_PREV; k++) begin
         if (idx_q == IDX_W'(k)) w_mark = prev_q[k*POS_W +: POS_W];
      end
   end

   // The c <= p test guards the subtraction; w_dbit is only meaningful when it passes.
   assign w_cand_lo = cand_q[POS_W-1:0];
   assign w_diff    = w_cand_lo - w_mark;
   assign w_dbit    = (w_diff == '0) ? '0 : (C_ONE << (w_diff - 1'b1));
   assign w_fail    = (cand_q <= {1'b0, w_mark}) || (|(w_dbit & (used_q | loc_q)));

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      idx_d   = idx_q;
      loc_d   = loc_q;
      prev_d  = prev_q;
      used_d  = used_q;
      val_d   = val_q;
      nsv_d   = nsv_q;
      uo_d    = uo_q;
      ready_d = ready_q;
      exh_d   = exh_q;
      if (load) begin
         prev_d  = prev_marks;
         used_d  = used_in;
         cand_d  = {1'b0, start_value};
         idx_d   = '0;
         loc_d   = '0;
         ready_d = 1'b0;
         exh_d   = 1'b0;
         nsv_d   = '0;
         uo_d    = '0;
         state_d = S_CHECK;
      end else begin
         case (state_q)
            S_CHECK: begin
               if (cand_q > C_MAX_LEN) begin
                  state_d = S_EXH;
                  exh_d   = 1'b1;
                  ready_d = 1'b0;
               end else if (w_fail) begin
                  cand_d = cand_q + 1'b1;
                  idx_d  = '0;
                  loc_d  = '0;
               end else if (idx_q != C_LAST_IDX) begin
                  loc_d = loc_q | w_dbit;
                  idx_d = idx_q + 1'b1;
               end else begin
                  state_d = S_FOUND;
                  val_d   = w_cand_lo;
                  nsv_d   = w_cand_lo + 1'b1;
                  uo_d    = used_q | loc_q | w_dbit;
                  ready_d = 1'b1;
               end
            end
            S_FOUND: begin
               if (advance) begin
                  state_d = S_CHECK;
                  cand_d  = {1'b0, val_q} + 1'b1;
                  idx_d   = '0;
                  loc_d   = '0;
                  ready_d = 1'b0;
                  nsv_d   = '0;
                  uo_d    = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cand_q  <= '0;
         idx_q   <= '0;
         loc_q   <= '0;
         prev_q  <= '0;
         used_q  <= '0;
         val_q   <= '0;
         nsv_q   <= '0;
         uo_q    <= '0;
         ready_q <= 1'b0;
         exh_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         idx_q   <= idx_d;
         loc_q   <= loc_d;
         prev_q  <= prev_d;
         used_q  <= used_d;
         val_q   <= val_d;
         nsv_q   <= nsv_d;
         uo_q    <= uo_d;
         ready_q <= ready_d;
         exh_q   <= exh_d;
      end
   end

   assign val            = val_q;
   assign nextStartValue = nsv_q;
   assign used_out       = uo_q;
   assign ready          = ready_q;
   assign exhausted      = exh_q;

endmodule
`default_nettype wire

// File: tb/tb_mark_counter_body.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mark_counter_body: vector table, corner sequences and random runs   |
// | against a distance-set reference model. Revision: 1.0                  |
// +------------------------------------------------------------------------+
module tb_mark_counter_body;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic        advance = 1'b0;
   logic [7:0]  start_value = '0;
   logic [24:0] used_in = '0;
   logic [15:0] pm2 = '0;
   logic [23:0] pm3 = '0;

   logic [7:0]  val0, val1, val2, nsv0, nsv1, nsv2;
   logic [24:0] uo0, uo1;
   logic [5:0]  uo2;
   logic        rdy0, rdy1, rdy2, exh0, exh1, exh2;

   int          sel = 0;
   logic [7:0]  o_val, o_nsv;
   logic [24:0] o_uo;
   logic        o_rdy, o_exh;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mark_counter_body #(.POS_W(8), .NUM_PREV(2), .MAX_LEN(25)) u0 (
      .clock(clock), .reset(reset), .load(load), .advance(advance),
      .start_value(start_value), .prev_marks(pm2), .used_in(used_in),
      .val(val0), .nextStartValue(nsv0), .used_out(uo0), .ready(rdy0), .exhausted(exh0));
   mark_counter_body #(.POS_W(8), .NUM_PREV(3), .MAX_LEN(25)) u1 (
      .clock(clock), .reset(reset), .load(load), .advance(advance),
      .start_value(start_value), .prev_marks(pm3), .used_in(used_in),
      .val(val1), .nextStartValue(nsv1), .used_out(uo1), .ready(rdy1), .exhausted(exh1));
   mark_counter_body #(.POS_W(8), .NUM_PREV(2), .MAX_LEN(6)) u2 (
      .clock(clock), .reset(reset), .load(load), .advance(advance),
      .start_value(start_value), .prev_marks(pm2), .used_in(used_in[5:0]),
      .val(val2), .nextStartValue(nsv2), .used_out(uo2), .ready(rdy2), .exhausted(exh2));

   always_comb begin
      o_val = val0; o_nsv = nsv0; o_uo = uo0; o_rdy = rdy0; o_exh = exh0;
      if (sel == 1) begin
         o_val = val1; o_nsv = nsv1; o_uo = uo1; o_rdy = rdy1; o_exh = exh1;
      end else if (sel == 2) begin
         o_val = val2; o_nsv = nsv2; o_uo = {19'd0, uo2}; o_rdy = rdy2; o_exh = exh2;
      end
   end

   typedef struct {
      int          sel;
      int          start;
      logic [24:0] used;
      int          m0, m1, m2;
      bit          found;
      int          v;
      logic [24:0] uo;
      int          cyc;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Search rules applied directly: walk candidates, track distances as a set.
   function automatic void model(input int start, input int m0, input int m1, input int m2,
                                 input int n, input logic [24:0] used, input int maxlen,
                                 output bit found, output int v, output logic [24:0] uo,
                                 output int cyc);
      int          mk[3];
      int          c, d;
      bit          ok;
      logic [24:0] seen;
      mk[0] = m0; mk[1] = m1; mk[2] = m2;
      found = 0; v = 0; uo = '0; cyc = 0;
      c = start;
      while (c <= maxlen) begin
         seen = '0;
         ok = 1;
         for (int i = 0; i < n && ok; i++) begin
            cyc++;
            d = c - mk[i];
            if (d <= 0) ok = 0;
            else if (used[d-1] || seen[d-1]) ok = 0;
            else seen[d-1] = 1'b1;
         end
         if (ok) begin
            found = 1; v = c; uo = used | seen;
            return;
         end
         c++;
      end
      cyc++;
   endfunction

   task automatic set_marks(input int m0, input int m1, input int m2);
      pm2 = {8'(m1), 8'(m0)};
      pm3 = {8'(m2), 8'(m1), 8'(m0)};
   endtask

   // Called at a negedge; returns at the negedge after the load edge with inputs scrambled.
   task automatic do_load(input int s, input logic [24:0] u, input int m0, input int m1,
                          input int m2, input bit adv);
      start_value = 8'(s);
      used_in = u;
      set_marks(m0, m1, m2);
      load = 1'b1;
      advance = adv;
      @(posedge clock);
      @(negedge clock);
      load = 1'b0;
      advance = 1'b0;
      start_value = 8'($urandom);
      used_in = 25'($urandom);
      pm2 = 16'($urandom);
      pm3 = 24'($urandom);
   endtask

   task automatic pulse_adv();
      advance = 1'b1;
      @(posedge clock);
      @(negedge clock);
      advance = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!(o_rdy || o_exh) && cyc < 300) begin
         @(posedge clock);
         @(negedge clock);
         cyc++;
      end
      if (!(o_rdy || o_exh)) check("timeout", 0, 1);
   endtask

   task automatic check_result(input string tag, input bit found, input int v,
                               input logic [24:0] uo, input int exp_cyc, input int cyc);
      check({tag, ".ready"}, o_rdy, found);
      check({tag, ".exhausted"}, o_exh, !found);
      check({tag, ".cycles"}, cyc, exp_cyc);
      if (found) begin
         check({tag, ".val"}, o_val, v);
         check({tag, ".used_out"}, o_uo, uo);
         check({tag, ".next"}, o_nsv, 8'(v + 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int          cyc, v, n, s, m1, m2, ecyc;
      bit          f;
      logic [24:0] u, euo;

      tbl[0] = '{0, 2, 25'h1,  0, 1, 0, 1, 3, 25'h7,  4};
      tbl[1] = '{1, 4, 25'h7,  0, 1, 3, 1, 7, 25'h6F, 11};
      tbl[2] = '{2, 6, 25'h1,  0, 1, 0, 1, 6, 25'h31, 2};
      tbl[3] = '{0, 0, 25'h0,  0, 1, 0, 1, 2, 25'h3,  5};
      tbl[4] = '{2, 7, 25'h1,  0, 1, 0, 0, 0, 25'h0,  1};

      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("rst.val", o_val, 0);
      check("rst.next", o_nsv, 0);
      check("rst.used_out", o_uo, 0);
      check("rst.ready", o_rdy, 0);
      check("rst.exhausted", o_exh, 0);

      for (int k = 0; k < 5; k++) begin
         sel = tbl[k].sel;
         do_load(tbl[k].start, tbl[k].used, tbl[k].m0, tbl[k].m1, tbl[k].m2, 0);
         wait_done(cyc);
         check_result($sformatf("tbl%0d", k), tbl[k].found, tbl[k].v, tbl[k].uo, tbl[k].cyc, cyc);
      end

      // Advance from val=3 to val=4.
      sel = 0;
      do_load(2, 25'h1, 0, 1, 0, 0);
      wait_done(cyc);
      pulse_adv();
      check("adv.ready_low", o_rdy, 0);
      check("adv.next_zero", o_nsv, 0);
      check("adv.used_zero", o_uo, 0);
      check("adv.val_hold", o_val, 3);
      wait_done(cyc);
      check_result("adv", 1, 4, 25'hD, 2, cyc);

      // Bound exhaustion on a short ruler, then recovery by load.
      sel = 2;
      do_load(6, 25'h1, 0, 1, 0, 0);
      wait_done(cyc);
      check("exh.first_val", o_val, 6);
      pulse_adv();
      check("exh.ready_low", o_rdy, 0);
      wait_done(cyc);
      check_result("exh", 0, 0, 0, 1, cyc);
      pulse_adv();
      repeat (3) begin @(posedge clock); @(negedge clock); end
      check("exh.hold", o_exh, 1);
      check("exh.hold_ready", o_rdy, 0);
      check("exh.val_hold", o_val, 6);
      do_load(2, 25'h1, 0, 1, 0, 0);
      check("exh.cleared", o_exh, 0);
      wait_done(cyc);
      check_result("exh.reload", 1, 3, 25'h7, 4, cyc);

      // Load and advance together while FOUND: load wins.
      sel = 0;
      do_load(2, 25'h1, 0, 1, 0, 0);
      wait_done(cyc);
      do_load(5, 25'h1, 0, 1, 0, 1);
      wait_done(cyc);
      check_result("ldadv", 1, 5, 25'h19, 2, cyc);

      // Reset during CHECK.
      do_load(2, 25'h1, 0, 1, 0, 0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("midrst.val", o_val, 0);
      check("midrst.next", o_nsv, 0);
      check("midrst.used", o_uo, 0);
      check("midrst.ready", o_rdy, 0);
      check("midrst.exh", o_exh, 0);
      pulse_adv();
      repeat (4) begin @(posedge clock); @(negedge clock); end
      check("midrst.adv_ready", o_rdy, 0);
      check("midrst.adv_val", o_val, 0);

      // Random loads with a few advances each.
      for (int t = 0; t < 40; t++) begin
         sel = int'($urandom_range(0, 1));
         n = (sel == 1) ? 3 : 2;
         m1 = int'($urandom_range(1, 6));
         m2 = m1 + int'($urandom_range(1, 6));
         u = '0;
         for (int b = 0; b < 25; b++) if ($urandom_range(0, 4) == 0) u[b] = 1'b1;
         s = int'($urandom_range(0, 27));
         model(s, 0, m1, m2, n, u, 25, f, v, euo, ecyc);
         do_load(s, u, 0, m1, m2, 0);
         wait_done(cyc);
         check_result($sformatf("rnd%0d", t), f, v, euo, ecyc, cyc);
         for (int a = 0; a < 3 && f; a++) begin
            model(v + 1, 0, m1, m2, n, u, 25, f, v, euo, ecyc);
            pulse_adv();
            wait_done(cyc);
            check_result($sformatf("rnd%0d.adv%0d", t, a), f, v, euo, ecyc + 0, cyc + 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mark_counter_body.md
Name: mark_counter_body

Overview:
- Intermediate mark of the Golomb ruler search chain; sits directly downstream of the head mark at position 0, or of another body mark.
- Takes the upstream marks' positions, their used-distance set and a start value.
- Searches upward for the smallest candidate position whose distances to all upstream marks are new and mutually distinct.
- Publishes that position, the extended distance set and the start value for the next mark. On request from downstream, resumes the search from the next candidate.

Parameters:
- POS_W, 8: width of a position value; equals the codebase's position width, PositionValueBitMax+1.
- NUM_PREV, 2: number of upstream marks, head included; must be at least 1.
- MAX_LEN, 25: largest legal position (ruler length bound); must be at most 2^POS_W-1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle pulse: capture inputs and start the search at start_value.
- advance  in  1  downstream request for the next valid position; honoured only in FOUND.
- start_value  in  POS_W  first candidate; upstream nextStartValue.
- prev_marks  in  NUM_PREV*POS_W  upstream positions; slice i is mark i; slice 0 is the head (0).
- used_in  in  MAX_LEN  used-distance set; bit k-1 set means distance k is already taken.
- val  out  POS_W  accepted position.
- nextStartValue  out  POS_W  val+1 while ready, else 0.
- used_out  out  MAX_LEN  used_in OR the distances from val to every upstream mark; valid while ready.
- ready  out  1  a valid position is held.
- exhausted  out  1  no candidate at or below MAX_LEN remains.

Behaviour:
- Reset: state IDLE. val, nextStartValue and used_out are 0; ready and exhausted are 0. Reset overrides load and advance in the same cycle.
- States: IDLE, CHECK, FOUND, EXHAUSTED.
- load, accepted in any state:
  - Captures start_value, prev_marks and used_in into internal registers.
  - Next cycle: state CHECK, candidate c=start_value, index i=0, local set L=0.
  - ready and exhausted drop to 0 in that next cycle.
- load has priority over advance when both are asserted.
- Entering CHECK with c > MAX_LEN: go to EXHAUSTED next cycle; exhausted=1, ready=0.
- CHECK, one upstream mark per cycle:
  - Compute d = c - p_i.
  - Fail if c <= p_i, or used_in bit d-1 is set, or L bit d-1 is set.
  - Fail: next cycle c=c+1, i=0, L cleared, and the bound test is reapplied.
  - Pass with i<NUM_PREV-1: set L bit d-1, i=i+1.
  - Pass with i=NUM_PREV-1: go to FOUND next cycle.
- On entering FOUND:
  - val=c, ready=1, nextStartValue=c+1.
  - used_out = captured used_in OR L OR bit d-1 of the final check.
- Latency: a candidate accepted on first try shows ready NUM_PREV+1 cycles after the load cycle. A failure at index i costs i+1 cycles.
- FOUND plus advance: next cycle ready=0, state CHECK with c=val+1, i=0, L=0.
  - val holds its old value.
  - used_out and nextStartValue read 0 until the next FOUND.
- advance in IDLE, CHECK or EXHAUSTED: ignored.
- EXHAUSTED: held until load or reset.
- Arithmetic:
  - Difference uses POS_W bits, guarded by the c <= p_i test.
  - c+1 is computed in POS_W+1 bits so that c=2^POS_W-1 cannot wrap. The result is compared against MAX_LEN, so it always terminates in EXHAUSTED.
- Inputs are sampled only at load. Changes to the inputs afterwards have no effect until the next load.

Test Plan:
- Reset mid-search: pulse load, assert reset during CHECK -> next cycle all outputs 0, state IDLE. A following advance has no effect.
- prev_marks={0,1}, used_in={1}, start_value=2, load -> c=2 fails (distance 1 used), c=3 passes. val=3, nextStartValue=4, used_out={1,2,3}, ready=1 exactly 5 cycles after load (1+1 fail, 1+2 pass).
- From FOUND val=3, pulse advance -> ready low next cycle, then val=4, used_out={1,3,4}, nextStartValue=5 after 3 further cycles.
- NUM_PREV=3, prev_marks={0,1,3}, used_in={1,2,3}, start_value=4 -> 4,5,6 fail. val=7, used_out={1,2,3,4,6,7}.
- MAX_LEN=6, prev_marks={0,1}, used_in={1}, start_value=6 -> val=6. advance -> c=7 exceeds the bound, so exhausted=1, ready=0. A further advance is ignored; a new load with start_value=2 clears exhausted and yields val=3.
- load and advance asserted together while FOUND -> load wins; the search restarts from the new start_value.
